// File: rtl/axis_pkt_sink_pkg.sv
// Shared types and default sizing for the AXI-Stream packet sink.
package axis_pkt_sink_pkg;

    localparam int unsigned DEF_TDATA_WIDTH   = 32;
    localparam int unsigned DEF_WORDS_PER_PKT = 8;
    localparam int unsigned DEF_FIFO_DEPTH    = 8;
    localparam int unsigned PKT_COUNT_W       = 16;

    // Packet framing FSM: waiting for a first beat, or inside a packet.
    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    // Bits needed to hold the values 0..n (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_pkt_fifo.sv
// Synchronous FIFO with registered read data. Writes to a full FIFO and
// reads from an empty FIFO are dropped; a pop never makes room for a push
// in the same cycle.
module axis_pkt_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_q == OCC_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Pointer, occupancy and read-register updates.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + OCC_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_pkt_sink.sv
// AXI-Stream packet sink: buffers every accepted beat for a local reader,
// checks packet framing against a fixed length, counts well-framed packets
// and reports the modular sum of the most recently ended packet.
module axis_pkt_sink
    import axis_pkt_sink_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int unsigned WORDS_PER_PKT        = DEF_WORDS_PER_PKT,
    parameter int unsigned FIFO_DEPTH           = DEF_FIFO_DEPTH
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    input  logic                              rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
    output logic                              rd_valid,
    output logic [PKT_COUNT_W-1:0]            pkt_count,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   pkt_sum,
    output logic                              len_err
);

    localparam int unsigned DW    = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned CNT_W = cnt_width(WORDS_PER_PKT);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_PKT);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]          run_sum_q, run_sum_d;
    logic [PKT_COUNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [DW-1:0]          pkt_sum_q, pkt_sum_d;
    logic                   len_err_q, len_err_d;
    logic                   tready_q, tready_d;

    logic                   accept;
    logic                   pop_ok;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [OCC_W-1:0]       fifo_count;
    logic [OCC_W-1:0]       occ_next;
    logic [CNT_W-1:0]       beat_num;
    logic                   pkt_end;
    logic                   framed_ok;
    logic                   strb_unused;

    // Strobes are assumed all-ones and carry no information here.
    assign strb_unused = ^S_AXIS_TSTRB;

    assign accept        = S_AXIS_TVALID && tready_q;
    assign pop_ok        = rd_en && !fifo_empty;
    assign S_AXIS_TREADY = tready_q;
    assign pkt_count     = pkt_count_q;
    assign pkt_sum       = pkt_sum_q;
    assign len_err       = len_err_q;

    // 1-based index of the beat currently on the bus within its packet.
    assign beat_num  = (state_q == IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
    assign pkt_end   = S_AXIS_TLAST || (beat_num == LAST_BEAT);
    assign framed_ok = S_AXIS_TLAST && (beat_num == LAST_BEAT);

    axis_pkt_fifo #(
        .DATA_W (DW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (S_AXIS_ACLK),
        .rst      (S_AXIS_ARESET),
        .push     (accept),
        .wr_data  (S_AXIS_TDATA),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Ready is registered from next-cycle occupancy so it stays low in reset
    // and never looks at TVALID. accept implies the FIFO is not full.
    always_comb begin
        occ_next = fifo_count;
        if (accept && !pop_ok) begin
            occ_next = fifo_count + OCC_W'(1);
        end else if (!accept && pop_ok) begin
            occ_next = fifo_count - OCC_W'(1);
        end
        tready_d = (occ_next != OCC_FULL) && !(fifo_full && !pop_ok && !accept && 1'b0);
    end

    // Framing FSM, beat counter, running sum and packet statistics.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        run_sum_d   = run_sum_q;
        pkt_count_d = pkt_count_q;
        pkt_sum_d   = pkt_sum_q;
        len_err_d   = len_err_q;
        if (accept) begin
            if (pkt_end) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                run_sum_d  = '0;
                pkt_sum_d  = run_sum_q + S_AXIS_TDATA;
                if (framed_ok) begin
                    pkt_count_d = pkt_count_q + PKT_COUNT_W'(1);
                end else begin
                    len_err_d = 1'b1;
                end
            end else begin
                state_d    = RECEIVE;
                beat_cnt_d = beat_num;
                run_sum_d  = run_sum_q + S_AXIS_TDATA;
            end
        end
    end

    // State registers.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            run_sum_q   <= '0;
            pkt_count_q <= '0;
            pkt_sum_q   <= '0;
            len_err_q   <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            run_sum_q   <= run_sum_d;
            pkt_count_q <= pkt_count_d;
            pkt_sum_q   <= pkt_sum_d;
            len_err_q   <= len_err_d;
            tready_q    <= tready_d;
        end
    end

endmodule
